servo_motion_sequencer: RTL and testbench
=========================================

SERVO_MOTION_SEQUENCER -- requirements
Module: servo_motion_sequencer

Interface
REQ-001 SHALL have parameter FRAME_CYCLES, default 500000, meaning CLK cycles per 20 ms servo frame at 25 MHz.
REQ-002 SHALL have parameter STEP_US, default 20, meaning max command change per servo per frame, in us.
REQ-003 SHALL have parameters MIN_US 650, MAX_US 2600, CENTER_US 1500, meaning clamp limits and home position, in us.
REQ-004 CLK  input  1  system clock; all logic on rising edge.
REQ-005 RST_N  input  1  reset, asynchronous, active-low.
REQ-006 target_valid  input  1  new target offered.
REQ-007 target_sel  input  2  servo index 0..3 for the offered target.
REQ-008 target_us  input  12  requested pulse width, us, unsigned.
REQ-009 target_ready  output  1  target accepted when target_valid && target_ready.
REQ-010 home_req  input  1  single-cycle request to start the homing sequence.
REQ-011 home_busy  output  1  homing sequence in progress.
REQ-012 frame_tick  output  1  one-cycle pulse at each frame boundary.
REQ-013 servo0_cmd..servo3_cmd  output  12 each  slewed pulse-width commands, us, to the four servo PWM generators.

Function
REQ-014 Frame counter SHALL count 0..FRAME_CYCLES-1 and wrap; frame_tick high exactly in the cycle the count equals FRAME_CYCLES-1.
REQ-015 An accepted target SHALL be clamped to [MIN_US, MAX_US] and stored in target register target_sel one cycle after the handshake.
REQ-016 target_ready SHALL be 1 in IDLE and UPDATE and 0 in HOME_WAIT; offers while not ready are dropped, not queued.
REQ-017 FSM states: IDLE, UPDATE, HOME_WAIT; UPDATE carries a 2-bit index idx.
REQ-018 On frame_tick in IDLE: next state UPDATE, idx=0; UPDATE steps servo idx per cycle, idx 0->1->2->3; after idx 3 the FSM returns to IDLE.
REQ-019 Step rule: diff = target - cmd, 13-bit signed; if |diff| <= STEP_US then cmd <= target, else cmd <= cmd +/- STEP_US; no overshoot, no wrap.
REQ-020 Latency: for a tick in cycle T, servoN_cmd SHALL change at the clock edge ending cycle T+1+N; at most one step per servo per frame.
REQ-021 A target write in the same cycle as frame_tick SHALL be visible to that frame's UPDATE pass.
REQ-022 A write during UPDATE to the servo being stepped in that cycle SHALL be stepped using the old target; the new target takes effect next frame.
REQ-023 A write during UPDATE to any other servo SHALL take effect whenever that servo is next read.
REQ-024 home_req in IDLE or UPDATE SHALL set home_busy next cycle and begin homing after the current UPDATE pass completes.
REQ-025 Homing order 3,2,1,0: set target[h] = CENTER_US, step on ticks as in REQ-018, advance h only once servo h cmd == CENTER_US.
REQ-026 A servo already at CENTER_US SHALL advance h in the next cycle without waiting for a frame.
REQ-027 After servo 0 reaches center the FSM SHALL go to IDLE and clear home_busy the same cycle.
REQ-028 home_req while home_busy=1 SHALL be ignored.
REQ-029 frame_tick SHALL keep running in all states; frame timing is never reset by writes or homing.

Reset
REQ-030 On RST_N low, immediately: all cmds and targets = CENTER_US, counter 0, FSM IDLE, idx/h 0, home_busy 0, frame_tick 0, target_ready 1.
REQ-031 Reset asserted mid-UPDATE or mid-homing SHALL abandon the sequence with no partial step retained; the first tick occurs FRAME_CYCLES cycles after release.

Structure
REQ-032 servo_pkg SHALL hold MIN_US, MAX_US, CENTER_US, the 12-bit command width, and the FSM state enum.
REQ-033 The frame counter SHALL be the sub-module servo_frame_timer, with ports CLK, RST_N, and tick.
REQ-034 Clamp and step logic SHALL be combinational within the top module; the only state is four cmd registers, four target registers, the FSM, idx, and h.

Verification (FRAME_CYCLES=16, STEP_US=20)
REQ-035 Reset then idle for 3 frames -> all cmds 1500 throughout; frame_tick every 16 cycles.
REQ-036 Write sel=1, target 1550 -> servo1_cmd 1520, 1540, 1550 on three successive frames at T+2, then constant.
REQ-037 Write sel=2, target 3000 -> stored target 2600; write sel=0, target 100 -> stored target 650; no cmd ever leaves [650, 2600].
REQ-038 Write sel=0 in the tick cycle -> that frame's step applied at T+1; write sel=2 at T+3 -> step uses old target, new target next frame.
REQ-039 Set servo3=1600 and servo1=1460 settled, then pulse home_req -> target_ready 0; servo3 steps 1580..1500; servo2 and servo0 skip in 1 cycle each; servo1 steps 1480, 1500; then IDLE, home_busy 0.
REQ-040 Assert RST_N low during homing -> cmds 1500 asynchronously, home_busy 0; second home_req during homing has no effect.

Source files
------------

// File: rtl/servo_pkg.sv
// Shared constants and types for the four-channel servo sequencer.
package servo_pkg;
    localparam int CMD_W     = 12;
    localparam int MIN_US    = 650;
    localparam int MAX_US    = 2600;
    localparam int CENTER_US = 1500;

    typedef logic [CMD_W-1:0] cmd_t;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_UPDATE    = 2'd1,
        ST_HOME_WAIT = 2'd2
    } state_e;
endpackage

// File: rtl/servo_frame_timer.sv
// Free-running frame counter; tick marks the last cycle of each frame.
module servo_frame_timer #(
    parameter int FRAME_CYCLES = 500000
) (
    input  logic CLK,
    input  logic RST_N,
    output logic tick
);
    localparam int CNT_W =
        (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(FRAME_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt <= '0;
        end else if (r_cnt == LP_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign tick = (r_cnt == LP_LAST);
endmodule

// File: rtl/servo_motion_sequencer.sv
// Slews four servo pulse-width commands toward clamped targets once per
// frame, with a sequential 3..0 homing mode.
module servo_motion_sequencer #(
    parameter int FRAME_CYCLES = 500000,
    parameter int STEP_US      = 20,
    parameter int MIN_US       = servo_pkg::MIN_US,
    parameter int MAX_US       = servo_pkg::MAX_US,
    parameter int CENTER_US    = servo_pkg::CENTER_US
) (
    input  logic                        CLK,
    input  logic                        RST_N,
    input  logic                        target_valid,
    input  logic [1:0]                  target_sel,
    input  logic [servo_pkg::CMD_W-1:0] target_us,
    output logic                        target_ready,
    input  logic                        home_req,
    output logic                        home_busy,
    output logic                        frame_tick,
    output logic [servo_pkg::CMD_W-1:0] servo0_cmd,
    output logic [servo_pkg::CMD_W-1:0] servo1_cmd,
    output logic [servo_pkg::CMD_W-1:0] servo2_cmd,
    output logic [servo_pkg::CMD_W-1:0] servo3_cmd
);
    import servo_pkg::*;

    localparam cmd_t LP_MIN  = cmd_t'(MIN_US);
    localparam cmd_t LP_MAX  = cmd_t'(MAX_US);
    localparam cmd_t LP_CTR  = cmd_t'(CENTER_US);
    localparam cmd_t LP_STEP = cmd_t'(STEP_US);

    state_e r_state, w_state_nxt;
    logic [1:0] r_idx, w_idx_nxt;
    logic [1:0] r_h, w_h_nxt;
    logic r_busy, w_busy_nxt;
    cmd_t r_cmd [4];
    cmd_t r_tgt [4];

    logic w_tick, w_wr, w_step_en, w_force;
    logic w_at_ctr, w_home_go;
    cmd_t w_clamped, w_step_val, w_cur_cmd, w_cur_tgt;
    logic signed [CMD_W:0] w_diff;
    logic [CMD_W:0] w_mag;

    servo_frame_timer #(
        .FRAME_CYCLES(FRAME_CYCLES)
    ) u_timer (
        .CLK  (CLK),
        .RST_N(RST_N),
        .tick (w_tick)
    );

    assign frame_tick   = w_tick;
    assign home_busy    = r_busy;
    assign target_ready = (r_state != ST_HOME_WAIT);
    assign w_wr         = target_valid && target_ready;
    assign w_home_go    = home_req && !r_busy;
    assign w_at_ctr     = (r_cmd[r_h] == LP_CTR);
    assign w_cur_cmd    = r_cmd[r_idx];
    assign w_cur_tgt    = r_tgt[r_idx];

    always_comb begin
        w_clamped = target_us;
        if (target_us < LP_MIN) begin
            w_clamped = LP_MIN;
        end else if (target_us > LP_MAX) begin
            w_clamped = LP_MAX;
        end
    end

    // Targets and cmds stay inside the clamp range, so +/- STEP never wraps.
    always_comb begin
        w_diff = $signed({1'b0, w_cur_tgt}) - $signed({1'b0, w_cur_cmd});
        w_mag  = w_diff[CMD_W] ? -w_diff : w_diff;
        w_step_val = w_cur_tgt;
        if (w_mag > {1'b0, LP_STEP}) begin
            w_step_val = w_diff[CMD_W] ? w_cur_cmd - LP_STEP
                                       : w_cur_cmd + LP_STEP;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_h_nxt     = r_h;
        w_busy_nxt  = r_busy;
        w_step_en   = 1'b0;
        w_force     = 1'b0;
        if (w_home_go) begin
            w_busy_nxt = 1'b1;
            w_h_nxt    = 2'd3;
        end
        unique case (r_state)
            ST_IDLE: begin
                if (w_tick) begin
                    w_state_nxt = ST_UPDATE;
                    w_idx_nxt   = 2'd0;
                end else if (w_home_go) begin
                    w_state_nxt = ST_HOME_WAIT;
                end
            end
            ST_UPDATE: begin
                w_step_en = 1'b1;
                w_idx_nxt = r_idx + 2'd1;
                if (r_idx == 2'd3) begin
                    w_state_nxt = (r_busy || w_home_go) ? ST_HOME_WAIT
                                                        : ST_IDLE;
                end
            end
            ST_HOME_WAIT: begin
                w_force = 1'b1;
                // A tick always starts a pass; h only advances off-tick.
                if (w_at_ctr && r_h == 2'd0) begin
                    w_busy_nxt  = 1'b0;
                    w_state_nxt = w_tick ? ST_UPDATE : ST_IDLE;
                    w_idx_nxt   = 2'd0;
                end else if (w_tick) begin
                    w_state_nxt = ST_UPDATE;
                    w_idx_nxt   = 2'd0;
                end else if (w_at_ctr) begin
                    w_h_nxt = r_h - 2'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
            r_idx   <= 2'd0;
            r_h     <= 2'd0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_h     <= w_h_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < 4; i++) begin
                r_cmd[i] <= LP_CTR;
                r_tgt[i] <= LP_CTR;
            end
        end else begin
            if (w_step_en) begin
                r_cmd[r_idx] <= w_step_val;
            end
            if (w_force) begin
                r_tgt[r_h] <= LP_CTR;
            end else if (w_wr) begin
                r_tgt[target_sel] <= w_clamped;
            end
        end
    end

    assign servo0_cmd = r_cmd[0];
    assign servo1_cmd = r_cmd[1];
    assign servo2_cmd = r_cmd[2];
    assign servo3_cmd = r_cmd[3];
endmodule

// File: tb/tb_servo_motion_sequencer.sv
// Bench for servo_motion_sequencer: frame-phase reference model,
// directed vector table, homing/reset sequences and random traffic.
module tb_servo_motion_sequencer;
    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        target_valid = 1'b0;
    logic [1:0]  target_sel = 2'd0;
    logic [11:0] target_us = 12'd0;
    logic        home_req = 1'b0;
    logic        target_ready, home_busy, frame_tick;
    logic [11:0] servo0_cmd, servo1_cmd, servo2_cmd, servo3_cmd;

    int checks = 0;
    int failures = 0;

    int m_cmd [4];
    int m_tgt [4];
    int m_cyc;
    int m_h;
    bit m_busy;

    typedef struct {
        int sel;
        int us;
        int frames;
        int exp;
    } vec_t;

    vec_t tbl [12];

    always #5 CLK = ~CLK;

    servo_motion_sequencer #(
        .FRAME_CYCLES(16),
        .STEP_US     (20)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .target_valid(target_valid),
        .target_sel  (target_sel),
        .target_us   (target_us),
        .target_ready(target_ready),
        .home_req    (home_req),
        .home_busy   (home_busy),
        .frame_tick  (frame_tick),
        .servo0_cmd  (servo0_cmd),
        .servo1_cmd  (servo1_cmd),
        .servo2_cmd  (servo2_cmd),
        .servo3_cmd  (servo3_cmd)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    function automatic int dut_cmd(input int n);
        case (n)
            0: return int'(servo0_cmd);
            1: return int'(servo1_cmd);
            2: return int'(servo2_cmd);
            default: return int'(servo3_cmd);
        endcase
    endfunction

    function automatic int clampv(input int v);
        if (v < 650) return 650;
        if (v > 2600) return 2600;
        return v;
    endfunction

    function automatic int slew(input int c, input int t);
        int d;
        d = t - c;
        if (d <= 20 && d >= -20) return t;
        return (d > 0) ? c + 20 : c - 20;
    endfunction

    // Every tick starts a pass: servo n is stepped in phase n of the
    // following frame. Homing acts in all other cycles while busy.
    function automatic bit m_pass();
        return (m_cyc >= 16) && ((m_cyc % 16) < 4);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_cmd[i] = 1500;
            m_tgt[i] = 1500;
        end
        m_cyc  = 0;
        m_h    = 0;
        m_busy = 1'b0;
    endtask

    task automatic model_update();
        int p;
        bit pass;
        bit rdy;
        bit go;
        p    = m_cyc % 16;
        pass = m_pass();
        rdy  = !(m_busy && !pass);
        go   = home_req && !m_busy;
        if (pass) m_cmd[p] = slew(m_cmd[p], m_tgt[p]);
        if (m_busy && !pass) begin
            m_tgt[m_h] = 1500;
            if (m_cmd[m_h] == 1500) begin
                if (m_h == 0) m_busy = 1'b0;
                else if (p != 15) m_h = m_h - 1;
            end
        end else if (target_valid && rdy) begin
            m_tgt[target_sel] = clampv(int'(target_us));
        end
        if (go) begin
            m_busy = 1'b1;
            m_h    = 3;
        end
        m_cyc++;
    endtask

    task automatic compare_all();
        int exp_rdy;
        exp_rdy = int'(!(m_busy && !m_pass()));
        for (int n = 0; n < 4; n++) begin
            chk($sformatf("cmd%0d cyc%0d", n, m_cyc), dut_cmd(n), m_cmd[n]);
        end
        chk($sformatf("ready cyc%0d", m_cyc), int'(target_ready), exp_rdy);
        chk($sformatf("busy cyc%0d", m_cyc), int'(home_busy), int'(m_busy));
        chk($sformatf("tick cyc%0d", m_cyc), int'(frame_tick),
            int'((m_cyc % 16) == 15));
    endtask

    task automatic step_cycle();
        @(negedge CLK);
        compare_all();
        @(posedge CLK);
        model_update();
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) step_cycle();
    endtask

    task automatic to_phase(input int p);
        for (int i = 0; i < 16; i++) begin
            if ((m_cyc % 16) == p) break;
            step_cycle();
        end
    endtask

    task automatic wait_frames(input int n);
        repeat (n) begin
            step_cycle();
            to_phase(4);
        end
    endtask

    task automatic write(input int sel, input int us);
        target_valid = 1'b1;
        target_sel   = 2'(sel);
        target_us    = 12'(us);
        step_cycle();
        target_valid = 1'b0;
    endtask

    task automatic pulse_home();
        home_req = 1'b1;
        step_cycle();
        home_req = 1'b0;
    endtask

    task automatic apply_reset();
        #2;
        RST_N = 1'b0;
        target_valid = 1'b0;
        home_req = 1'b0;
        #1;
        chk("rst_cmd0", int'(servo0_cmd), 1500);
        chk("rst_cmd1", int'(servo1_cmd), 1500);
        chk("rst_cmd2", int'(servo2_cmd), 1500);
        chk("rst_cmd3", int'(servo3_cmd), 1500);
        chk("rst_busy", int'(home_busy), 0);
        chk("rst_ready", int'(target_ready), 1);
        chk("rst_tick", int'(frame_tick), 0);
        model_reset();
        @(posedge CLK);
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int ticks;
        int n;
        int q3[$];
        int q1[$];
        int last3, last1, t3, t1;
        int e3 [5];
        int e1 [2];

        tbl[0]  = '{1, 1550, 1, 1520};
        tbl[1]  = '{1, 1550, 1, 1540};
        tbl[2]  = '{1, 1550, 1, 1550};
        tbl[3]  = '{1, 1550, 2, 1550};
        tbl[4]  = '{2, 3000, 1, 1520};
        tbl[5]  = '{0, 100, 1, 1480};
        tbl[6]  = '{0, 650, 3, 1420};
        tbl[7]  = '{3, 1510, 1, 1510};
        tbl[8]  = '{3, 1495, 1, 1495};
        tbl[9]  = '{2, 1500, 1, 1620};
        tbl[10] = '{3, 4095, 60, 2600};
        tbl[11] = '{3, 0, 100, 650};
        e3 = '{1580, 1560, 1540, 1520, 1500};
        e1 = '{1480, 1500};

        model_reset();
        @(posedge CLK);
        #1;
        apply_reset();

        ticks = 0;
        repeat (48) begin
            step_cycle();
            if (frame_tick) ticks++;
        end
        chk("idle_ticks", ticks, 3);

        to_phase(4);
        for (int i = 0; i < 12; i++) begin
            write(tbl[i].sel, tbl[i].us);
            wait_frames(tbl[i].frames);
            chk($sformatf("tbl%0d", i), dut_cmd(tbl[i].sel), tbl[i].exp);
        end

        to_phase(15);
        write(0, 700);
        chk("tickwr_hold", int'(servo0_cmd), 650);
        step_cycle();
        chk("tickwr_step", int'(servo0_cmd), 670);
        step_cycle();
        write(2, 1600);
        chk("midwr_old", int'(servo2_cmd), 1500);
        to_phase(4);
        wait_frames(1);
        chk("midwr_new", int'(servo2_cmd), 1520);
        chk("tickwr_next", int'(servo0_cmd), 690);

        apply_reset();
        to_phase(4);
        write(3, 1600);
        write(1, 1460);
        wait_frames(6);
        chk("home_pre_s3", int'(servo3_cmd), 1600);
        chk("home_pre_s1", int'(servo1_cmd), 1460);
        pulse_home();
        chk("home_ready0", int'(target_ready), 0);
        chk("home_busy1", int'(home_busy), 1);
        last3 = 1600;
        last1 = 1460;
        t3 = 0;
        t1 = -1;
        n = 0;
        while (home_busy && n < 600) begin
            step_cycle();
            n++;
            if (int'(servo3_cmd) != last3) begin
                last3 = int'(servo3_cmd);
                q3.push_back(last3);
                t3 = n;
            end
            if (int'(servo1_cmd) != last1) begin
                last1 = int'(servo1_cmd);
                q1.push_back(last1);
                if (t1 < 0) t1 = n;
            end
        end
        chk("home_done", int'(home_busy), 0);
        chk("home_ready1", int'(target_ready), 1);
        chk("home_s3_n", q3.size(), 5);
        for (int i = 0; i < q3.size() && i < 5; i++) begin
            chk($sformatf("home_s3_%0d", i), q3[i], e3[i]);
        end
        chk("home_s1_n", q1.size(), 2);
        for (int i = 0; i < q1.size() && i < 2; i++) begin
            chk($sformatf("home_s1_%0d", i), q1[i], e1[i]);
        end
        chk("home_order", int'(t1 > t3), 1);
        chk("home_s0", int'(servo0_cmd), 1500);
        chk("home_s2", int'(servo2_cmd), 1500);

        to_phase(4);
        write(2, 1700);
        write(0, 1300);
        wait_frames(11);
        pulse_home();
        run(40);
        chk("c_busy_a", int'(home_busy), 1);
        pulse_home();
        run(20);
        chk("c_busy_b", int'(home_busy), 1);
        chk("c_s2_mid", int'(servo2_cmd != 12'd1500), 1);
        apply_reset();
        n = 0;
        while (!frame_tick && n < 40) begin
            step_cycle();
            n++;
        end
        chk("first_tick", n, 15);
        chk("post_rst_s2", int'(servo2_cmd), 1500);

        for (int i = 0; i < 3000; i++) begin
            target_valid = ($urandom_range(0, 2) == 0);
            target_sel   = 2'($urandom_range(0, 3));
            target_us    = 12'($urandom_range(0, 4095));
            home_req     = ($urandom_range(0, 199) == 0);
            step_cycle();
        end
        target_valid = 1'b0;
        home_req = 1'b0;
        run(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
